inst_sram_responder: RTL and testbench

//  Responder end of the inst_sram_* port driven by the fetch stage. It is a single-port, word-wide

---
 rtl/inst_sram_responder_pkg.sv | 5 +
 rtl/sram_1rw_be.sv | 25 ++
 rtl/inst_sram_responder.sv | 91 +++++++++
 tb/tb_inst_sram_responder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/inst_sram_responder_pkg.sv
// inst_sram_responder_pkg: shared NOP instruction and responder state encoding.
package inst_sram_responder_pkg;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    typedef enum logic {IDLE, LOAD} state_e;
endpackage

// File: rtl/sram_1rw_be.sv
// sram_1rw_be: single-port word RAM, byte-enable writes, read-first, registered output that holds when idle.
module sram_1rw_be #(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            for (int b = 0; b < 4; b++)
                if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/inst_sram_responder.sv
// inst_sram_responder: instruction memory responder for the fetch stage with a streaming image loader.
module inst_sram_responder
    import inst_sram_responder_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = INST_NOP,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        ld_start,
    input  logic [31:0] ld_base,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_busy,
    output logic        addr_err
);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    state_e        state_q;
    logic [AW-1:0] ptr_q;
    logic          nop_q, addr_err_q, ld_busy_q, ld_ready_q;
    logic [31:0]   acc_off, ld_off, sram_rdata;
    logic          in_range, core_go, load_go;

    assign acc_off  = inst_sram_addr - BASE_ADDR;
    assign ld_off   = ld_base - BASE_ADDR;
    assign in_range = acc_off < SPAN;
    assign core_go  = !reset && state_q == IDLE && !ld_start && inst_sram_en && in_range;
    assign load_go  = !reset && state_q == LOAD && ld_valid;

    sram_1rw_be #(.DEPTH(DEPTH)) u_sram (
        .clk     (clk),
        .en_i    (core_go || load_go),
        .we_i    (load_go ? 4'hF : inst_sram_we),
        .addr_i  (load_go ? ptr_q : AW'(acc_off >> 2)),
        .wdata_i (load_go ? ld_data : inst_sram_wdata),
        .rdata_o (sram_rdata)
    );

    // nop_q masks the RAM output; both hold together when the core port is idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            nop_q      <= 1'b1;
            addr_err_q <= 1'b0;
            ld_busy_q  <= 1'b0;
            ld_ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld_start) begin
                        state_q    <= LOAD;
                        ptr_q      <= AW'(ld_off >> 2);
                        nop_q      <= 1'b1;
                        ld_busy_q  <= 1'b1;
                        ld_ready_q <= 1'b1;
                    end else if (inst_sram_en) begin
                        nop_q <= !in_range;
                        if (!in_range) addr_err_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        ptr_q <= ptr_q + AW'(1);
                        if (ld_last) begin
                            state_q    <= IDLE;
                            ld_busy_q  <= 1'b0;
                            ld_ready_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign inst_sram_rdata = nop_q ? NOP_WORD : sram_rdata;
    assign ld_ready        = ld_ready_q;
    assign ld_busy         = ld_busy_q;
    assign addr_err        = addr_err_q;
endmodule

// File: tb/tb_inst_sram_responder.sv
// tb_inst_sram_responder: directed self-checking bench for the instruction memory responder.
module tb_inst_sram_responder;
    localparam int DEPTH = 1024;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0, reset = 1'b1;
    logic        en = 1'b0, ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [3:0]  we = 4'h0;
    logic [31:0] addr = '0, wdata = '0, ld_base = '0, ld_data = '0, rdata;
    logic        ld_ready, ld_busy, addr_err;
    int          checks = 0, errors = 0;

    logic [31:0] a_img [4] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};

    always #5 clk = ~clk;

    inst_sram_responder dut (
        .clk(clk), .reset(reset),
        .inst_sram_en(en), .inst_sram_we(we), .inst_sram_addr(addr),
        .inst_sram_wdata(wdata), .inst_sram_rdata(rdata),
        .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .ld_busy(ld_busy), .addr_err(addr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read(input logic [31:0] a);
        en = 1'b1; we = 4'h0; addr = a;
        tick();
        en = 1'b0;
    endtask

    task automatic write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        en = 1'b1; we = be; addr = a; wdata = d;
        tick();
        en = 1'b0; we = 4'h0;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        check("reset_rdata", rdata, NOP);
        check("reset_ld_ready", 32'(ld_ready), 0);
        check("reset_ld_busy", 32'(ld_busy), 0);
        check("reset_addr_err", 32'(addr_err), 0);

        read(32'hFFFF_FFFC);
        check("oor_rdata", rdata, NOP);
        check("oor_addr_err", 32'(addr_err), 1);

        ld_start = 1'b1; ld_base = 32'h0;
        tick();
        ld_start = 1'b0;
        check("load_busy", 32'(ld_busy), 1);
        check("load_ready", 32'(ld_ready), 1);
        check("load_rdata_nop", rdata, NOP);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_data = a_img[i]; ld_last = (i == 3);
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        check("load_done_busy", 32'(ld_busy), 0);
        check("load_done_ready", 32'(ld_ready), 0);
        for (int i = 0; i < 4; i++) begin
            read(32'(i * 4));
            check($sformatf("img_read%0d", i), rdata, a_img[i]);
        end
        check("addr_err_sticky", 32'(addr_err), 1);

        read(32'h8);
        check("stall_read", rdata, a_img[2]);
        for (int i = 0; i < 3; i++) begin
            addr = 32'hC;
            tick();
            check($sformatf("stall_hold%0d", i), rdata, a_img[2]);
        end

        write(32'h4, 4'hF, 32'h1122_3344);
        write(32'h4, 4'b0101, 32'hAABB_CCDD);
        check("be_read_first", rdata, 32'h1122_3344);
        read(32'h4);
        check("be_merged", rdata, 32'h11BB_33DD);

        ld_start = 1'b1; ld_base = 32'((DEPTH - 1) * 4);
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'hC0DE_0000;
        tick();
        check("wrap_busy_mid", 32'(ld_busy), 1);
        ld_data = 32'hC0DE_0001; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("wrap_busy_fall", 32'(ld_busy), 0);
        read(32'((DEPTH - 1) * 4));
        check("wrap_top", rdata, 32'hC0DE_0000);
        read(32'h0);
        check("wrap_zero", rdata, 32'hC0DE_0001);
        check("addr_err_load_no_set", 32'(addr_err), 1);

        write(32'h10, 4'hF, 32'h4444_4444);
        write(32'h14, 4'hF, 32'h5555_5555);
        write(32'h18, 4'hF, 32'h6666_6666);
        write(32'h1C, 4'hF, 32'h7777_7777);
        read(32'h10);
        check("pre_load_read", rdata, 32'h4444_4444);
        en = 1'b1; addr = 32'h0; ld_start = 1'b1; ld_base = 32'h10;
        tick();
        en = 1'b0; ld_start = 1'b0;
        check("start_priority_nop", rdata, NOP);
        ld_valid = 1'b1; ld_data = 32'hB000_0004;
        tick();
        ld_data = 32'hB000_0005;
        tick();
        reset = 1'b1; ld_data = 32'hB000_0006;
        tick();
        reset = 1'b0; ld_valid = 1'b0;
        check("rst_mid_ready", 32'(ld_ready), 0);
        check("rst_mid_busy", 32'(ld_busy), 0);
        check("rst_mid_rdata", rdata, NOP);
        check("rst_mid_addr_err", 32'(addr_err), 0);
        read(32'h10);
        check("rst_word4", rdata, 32'hB000_0004);
        read(32'h14);
        check("rst_word5", rdata, 32'hB000_0005);
        read(32'h18);
        check("rst_word6", rdata, 32'h6666_6666);
        read(32'h1C);
        check("rst_word7", rdata, 32'h7777_7777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
